// File: rtl/inst_dispatch.sv
// Instruction dispatcher: decodes the FIFO head and waits for the target unit and its dependencies to be idle.
// It then issues a one-cycle configuration pulse with a registered payload and pops the FIFO.
//
// state  | meaning
// S_WAIT | head examined each cycle, issue once target and dependencies are idle
// S_GAP  | bubble after a pop so the FIFO advances and the target drops idle
// S_HALT | HALT consumed, parked until go
module inst_dispatch #(
   parameter int INST_LEN = 160,
   parameter int OP_LEN   = 4,
   parameter int N_LD     = 2,
   parameter int CNT_LEN  = 16,
   localparam int PAY_LEN = INST_LEN - OP_LEN - N_LD - 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INST_LEN-1:0] instruct,
   input  logic                inst_empty,
   output logic                inst_req,
   input  logic                cmp_idle,
   output logic                cmp_conf,
   input  logic [N_LD-1:0]     ld_idle,
   output logic [N_LD-1:0]     ld_conf,
   output logic [PAY_LEN-1:0]  payload,
   input  logic                go,
   output logic                halted,
   output logic                err_illegal,
   output logic [CNT_LEN-1:0]  inst_count
);

   localparam logic [OP_LEN-1:0] OP_CMP   = '0;
   localparam logic [OP_LEN-1:0] OP_FENCE = OP_LEN'((1 << OP_LEN) - 2);
   localparam logic [OP_LEN-1:0] OP_HALT  = OP_LEN'((1 << OP_LEN) - 1);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_GAP  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [OP_LEN-1:0]  op;
   logic [N_LD:0]      dep;
   logic [PAY_LEN-1:0] pay;
   logic [N_LD:0]      idle_vec;
   logic [N_LD-1:0]    ld_sel;
   logic               is_cmp, is_ld, deps_ok, tgt_idle;

   logic               cmp_conf_nx, inst_req_nx, halted_nx, err_nx, pay_ld;
   logic [N_LD-1:0]    ld_conf_nx;

   assign op       = instruct[OP_LEN-1:0];
   assign dep      = instruct[OP_LEN+N_LD:OP_LEN];
   assign pay      = instruct[INST_LEN-1:OP_LEN+N_LD+1];
   assign idle_vec = {cmp_idle, ld_idle};
   assign is_cmp   = (op == OP_CMP);
   assign is_ld    = (op != OP_CMP) && (op <= OP_LEN'(N_LD));
   // a set dep bit that names the target itself is already covered by tgt_idle
   assign deps_ok  = &(idle_vec | ~dep);
   assign tgt_idle = is_cmp ? cmp_idle : |(ld_sel & ld_idle);

   always_comb begin
      ld_sel = '0;
      for (int k = 0; k < N_LD; k++)
         ld_sel[k] = (op == OP_LEN'(k + 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_WAIT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      cmp_conf_nx = 1'b0;
      ld_conf_nx  = '0;
      inst_req_nx = 1'b0;
      pay_ld      = 1'b0;
      halted_nx   = halted;
      err_nx      = err_illegal;
      case (state)
         S_WAIT: begin
            if (!inst_empty) begin
               if (is_cmp || is_ld) begin
                  if (tgt_idle && deps_ok) begin
                     cmp_conf_nx = is_cmp;
                     ld_conf_nx  = ld_sel;
                     inst_req_nx = 1'b1;
                     pay_ld      = 1'b1;
                     state_nx    = S_GAP;
                  end
               end else if (op == OP_FENCE) begin
                  if (&idle_vec) begin
                     inst_req_nx = 1'b1;
                     state_nx    = S_GAP;
                  end
               end else if (op == OP_HALT) begin
                  inst_req_nx = 1'b1;
                  halted_nx   = 1'b1;
                  state_nx    = S_HALT;
               end else begin
                  inst_req_nx = 1'b1;
                  err_nx      = 1'b1;
                  state_nx    = S_GAP;
               end
            end
         end
         S_GAP: state_nx = S_WAIT;
         S_HALT: begin
            if (go) begin
               halted_nx = 1'b0;
               state_nx  = S_WAIT;
            end
         end
         default: state_nx = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_conf    <= 1'b0;
         ld_conf     <= '0;
         inst_req    <= 1'b0;
         payload     <= '0;
         halted      <= 1'b0;
         err_illegal <= 1'b0;
         inst_count  <= '0;
      end else begin
         cmp_conf    <= cmp_conf_nx;
         ld_conf     <= ld_conf_nx;
         inst_req    <= inst_req_nx;
         halted      <= halted_nx;
         err_illegal <= err_nx;
         if (pay_ld)      payload    <= pay;
         if (inst_req_nx) inst_count <= inst_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_dispatch.sv
// Bench for inst_dispatch: directed reset/first-issue checks, then randomized instruction streams
// scored against a rule-level model through a timestamped expectation queue.
module tb_inst_dispatch;
   localparam int INST_LEN = 160;
   localparam int OP_LEN   = 4;
   localparam int N_LD     = 2;
   localparam int CNT_LEN  = 8;   // narrow counter so the wrap is reached many times
   localparam int PAY_LEN  = INST_LEN - OP_LEN - N_LD - 1;
   localparam int OPF      = (1 << OP_LEN) - 2;
   localparam int OPH      = (1 << OP_LEN) - 1;

   logic                clk, rst_n;
   logic [INST_LEN-1:0] instruct;
   logic                inst_empty, inst_req, cmp_idle, cmp_conf, go, halted, err_illegal;
   logic [N_LD-1:0]     ld_idle, ld_conf;
   logic [PAY_LEN-1:0]  payload;
   logic [CNT_LEN-1:0]  inst_count;

   inst_dispatch #(.INST_LEN(INST_LEN), .OP_LEN(OP_LEN), .N_LD(N_LD), .CNT_LEN(CNT_LEN)) dut (
      .clk(clk), .rst_n(rst_n), .instruct(instruct), .inst_empty(inst_empty), .inst_req(inst_req),
      .cmp_idle(cmp_idle), .cmp_conf(cmp_conf), .ld_idle(ld_idle), .ld_conf(ld_conf),
      .payload(payload), .go(go), .halted(halted), .err_illegal(err_illegal), .inst_count(inst_count)
   );

   typedef struct {
      int                 stamp;
      bit                 resume;
      bit                 cmp;
      logic [N_LD-1:0]    ld;
      logic [PAY_LEN-1:0] pay;
      int                 cnt;
      bit                 err;
      bit                 hlt;
   } rec_t;

   rec_t                sb[$];
   logic [INST_LEN-1:0] fifo[$];
   int total = 0, bad = 0, cyc = 0;
   bit mon_en = 0, prev_conf = 0;

   // model state
   bit m_gap, m_halt, m_err, refill;
   int n_issued, idle_pct, fill_pct;
   logic [PAY_LEN-1:0] m_pay;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [INST_LEN-1:0] act, input logic [INST_LEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [INST_LEN-1:0] gen_word();
      logic [INST_LEN-1:0] w;
      int r, op;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      r = $urandom_range(99);
      if (r < 40)      op = 0;
      else if (r < 70) op = $urandom_range(N_LD, 1);
      else if (r < 80) op = OPF;
      else if (r < 85) op = OPH;
      else             op = $urandom_range(OPF - 1, N_LD + 1);
      w[OP_LEN-1:0] = OP_LEN'(op);
      if ($urandom_range(1) == 0) w[OP_LEN+N_LD:OP_LEN] = '0;
      return w;
   endfunction

   task automatic step();
      logic [INST_LEN-1:0] w;
      logic [N_LD:0]       idl, dep;
      int  op;
      bit  ready;
      rec_t r;
      @(posedge clk);
      #1;
      if (refill && fifo.size() < 4 && $urandom_range(99) < fill_pct) fifo.push_back(gen_word());
      inst_empty = (fifo.size() == 0);
      instruct   = inst_empty ? gen_word() : fifo[0];
      cmp_idle   = ($urandom_range(99) < idle_pct);
      for (int k = 0; k < N_LD; k++) ld_idle[k] = ($urandom_range(99) < idle_pct);
      go = ($urandom_range(3) == 0);

      if (m_gap) m_gap = 0;
      else if (m_halt) begin
         if (go) begin
            m_halt = 0;
            r = '{stamp: cyc + 1, resume: 1, cmp: 0, ld: '0, pay: '0, cnt: 0, err: 0, hlt: 0};
            sb.push_back(r);
         end
      end else if (fifo.size() > 0) begin
         w   = fifo[0];
         op  = int'(w[OP_LEN-1:0]);
         dep = w[OP_LEN+N_LD:OP_LEN];
         idl = {cmp_idle, ld_idle};
         if (op == 0)         ready = cmp_idle && ((dep & ~idl) == 0);
         else if (op <= N_LD) ready = ld_idle[op-1] && ((dep & ~idl) == 0);
         else if (op == OPF)  ready = &idl;
         else                 ready = 1;
         if (ready) begin
            void'(fifo.pop_front());
            n_issued++;
            r.ld = '0;
            if (op <= N_LD) m_pay = w[INST_LEN-1:OP_LEN+N_LD+1];
            if (op >= 1 && op <= N_LD) r.ld[op-1] = 1'b1;
            if (op > N_LD && op < OPF) m_err = 1;
            r.stamp = cyc + 1; r.resume = 0; r.cmp = (op == 0); r.pay = m_pay;
            r.cnt = n_issued % (1 << CNT_LEN); r.err = m_err; r.hlt = (op == OPH);
            sb.push_back(r);
            if (op == OPH) m_halt = 1;
            else           m_gap = 1;
         end
      end
   endtask

   rec_t mr;
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         total++;
         if (((cmp_conf || ld_conf != 0) && (!inst_req || prev_conf)) || $countones({cmp_conf, ld_conf}) > 1) begin
            bad++;
            $display("FAIL protocol: cmp_conf=%b ld_conf=%b inst_req=%b prev_conf=%b (cycle %0d)",
                     cmp_conf, ld_conf, inst_req, prev_conf, cyc);
         end
         prev_conf = cmp_conf || (ld_conf != 0);
         if (sb.size() > 0 && sb[0].stamp < cyc) begin
            total++; bad++;
            $display("FAIL missed_event: expected at cycle %0d, now %0d", sb[0].stamp, cyc);
            void'(sb.pop_front());
         end
         if (inst_req) begin
            if (sb.size() == 0 || sb[0].resume || sb[0].stamp != cyc) begin
               total++; bad++;
               $display("FAIL unexpected_pop: inst_req=1 with no issue expected (cycle %0d)", cyc);
            end else begin
               mr = sb.pop_front();
               chk("cmp_conf", cmp_conf, mr.cmp);
               chk("ld_conf", ld_conf, mr.ld);
               chk("payload", payload, mr.pay);
               chk("inst_count", inst_count, mr.cnt);
               chk("err_illegal", err_illegal, mr.err);
               chk("halted", halted, mr.hlt);
            end
         end else if (sb.size() > 0 && sb[0].stamp == cyc) begin
            mr = sb.pop_front();
            if (mr.resume) chk("resume_halted", halted, 0);
            else begin
               total++; bad++;
               $display("FAIL missing_pop: inst_req=0, issue expected (cycle %0d)", cyc);
            end
         end
      end
   end

   initial begin
      logic [INST_LEN-1:0] w;
      rst_n = 0; inst_empty = 1; instruct = '0; cmp_idle = 1; ld_idle = '1; go = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_inst_req", inst_req, 0);
      chk("rst_conf", {cmp_conf, ld_conf}, 0);
      chk("rst_payload", payload, 0);
      chk("rst_count", inst_count, 0);
      chk("rst_flags", {halted, err_illegal}, 0);
      rst_n = 1;
      w = '0;
      w[OP_LEN-1:0] = 4'd2;
      w[OP_LEN+N_LD+1 +: 8] = 8'h5A;
      instruct = w; inst_empty = 0;
      @(posedge clk);
      #1;
      inst_empty = 1;
      chk("load_ld_conf", ld_conf, 2'b10);
      chk("load_cmp_conf", cmp_conf, 0);
      chk("load_inst_req", inst_req, 1);
      chk("load_payload", payload, 8'h5A);
      chk("load_count", inst_count, 1);
      #2 rst_n = 0;
      #1;
      chk("midrst_conf", {cmp_conf, ld_conf}, 0);
      chk("midrst_inst_req", inst_req, 0);
      chk("midrst_payload", payload, 0);
      chk("midrst_count", inst_count, 0);
      @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk);
      #1;
      chk("post_rst_quiet", {inst_req, cmp_conf, ld_conf, halted}, 0);

      m_gap = 0; m_halt = 0; m_err = 0; n_issued = 0; m_pay = '0; refill = 1;
      mon_en = 1;
      for (int ph = 0; ph < 3; ph++) begin
         idle_pct = (ph == 0) ? 100 : (ph == 1) ? 80 : 45;
         fill_pct = (ph == 0) ? 100 : 70;
         repeat (1500) step();
      end
      refill = 0;
      repeat (60) step();
      @(negedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      chk("final_count", inst_count, n_issued % (1 << CNT_LEN));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_dispatch.md
# inst_dispatch

Parametrised instruction dispatcher sitting between the instruction FIFO and the accelerator's execution units (one compute pipe plus N_LD DDR load engines, e.g. weight and bias fetchers). It decodes opcode and dependency fields, waits until the target and every unit named in the dependency mask are idle, then issues a one-cycle configuration pulse with a registered payload and pops the FIFO. Beyond the fixed two-loader controller it replaces, it adds a generic dependency mask, FENCE/HALT opcodes, illegal-opcode detection and an issue counter.

## Interface
- INST_LEN, 160, instruction word width
- OP_LEN, 4, opcode field width; N_LD must be ≤ 2^OP_LEN − 3
- N_LD, 2, number of load engines
- CNT_LEN, 16, issue counter width
- PAY_LEN, INST_LEN−OP_LEN−N_LD−1 (derived localparam), payload width
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- instruct  in  INST_LEN  show-ahead head of instruction FIFO: [OP_LEN-1:0] opcode, next N_LD+1 bits dep mask (bit k = loader k, bit N_LD = compute), remainder payload
- inst_empty  in  1  FIFO empty
- inst_req  out  1  pop pulse, one cycle per consumed instruction
- cmp_idle  in  1  compute pipe idle
- cmp_conf  out  1  compute start pulse
- ld_idle  in  N_LD  per-loader idle
- ld_conf  out  N_LD  per-loader start pulse, one-hot or zero
- payload  out  PAY_LEN  registered payload, valid while conf high and held until next issue
- go  in  1  resume pulse after HALT
- halted  out  1  HALT reached, waiting for go
- err_illegal  out  1  sticky, illegal opcode seen
- inst_count  out  CNT_LEN  instructions consumed, wraps at 2^CNT_LEN

## Operation
- Opcodes: 0 = COMPUTE; 1..N_LD = LOAD to loader op−1; 2^OP_LEN−2 = FENCE; 2^OP_LEN−1 = HALT; all others illegal.
- States: S_WAIT, S_GAP, S_HALT. Reset → S_WAIT.
- S_WAIT, inst_empty=1: no action.
- S_WAIT, head valid, ready = (target idle) AND (idle of every unit whose dep bit is 1):
  - COMPUTE/LOAD, ready: payload ← instruct payload field; target conf ← 1; inst_req ← 1; inst_count+1; → S_GAP.
  - FENCE: ready when cmp_idle and all ld_idle high (mask ignored); inst_req ← 1, count+1, no conf; → S_GAP.
  - HALT: immediately inst_req ← 1, count+1, halted ← 1; → S_HALT.
  - Illegal: immediately inst_req ← 1, count+1, err_illegal ← 1, no conf; → S_GAP.
  - Not ready: hold, no outputs change.
- S_GAP: all conf and inst_req ← 0; → S_WAIT (one bubble lets FIFO advance and target drop idle).
- S_HALT: outputs quiet; on go=1, halted ← 0, → S_WAIT. go ignored outside S_HALT.
- Dep bit equal to the target's own bit is redundant, no effect.
- err_illegal cleared only by reset.

## Timing
- All outputs registered; reset value of every output 0 (payload, inst_count included), asserted asynchronously — conf/inst_req drop immediately on rst_n low mid-issue; the in-flight instruction is not popped if reset arrives before the rising edge that would pop it.
- Decision in cycle t (S_WAIT) → conf/inst_req high in cycle t+1 only → earliest next decision cycle t+2. Max issue rate: one instruction per 2 cycles.
- Units must drop idle no later than the cycle after sampling conf; dispatcher re-samples idle at t+2.
- FIFO must present the next word by t+2 after inst_req at t+1.
- Never two conf bits high in the same cycle; conf never high for two consecutive cycles.
- inst_count increments in the same cycle inst_req is high; wraps 2^CNT_LEN−1 → 0.

## Test plan
- Reset: rst_n low mid-issue (conf high) → conf, inst_req, payload, inst_count all 0 same cycle; state S_WAIT after release.
- LOAD op=2, dep=0, ld_idle=2'b11, payload 0x5A → ld_conf=2'b10 and inst_req high one cycle at t+1, payload=0x5A, inst_count=1.
- COMPUTE with dep bit 0 set, ld_idle[0]=0 for 10 cycles → no conf; cmp_conf pulses at the cycle after ld_idle[0] rises.
- Back-to-back: four COMPUTE words, all idle stuck high → cmp_conf pulses every 2 cycles, inst_count=4, never consecutive highs.
- FENCE then HALT with cmp_idle low 5 cycles → FENCE popped only after cmp_idle high; HALT popped next, halted=1; go pulse → halted=0, next instruction issued.
- Opcode 5 (N_LD=2) → popped, err_illegal=1 stays set, no conf, inst_count+1; counter at 0xFFFF + one issue → 0x0000.
